// File: rtl/vga_video_gen.sv
// vga_video_gen: VGA raster timing plus selectable test-pattern pixel source.
// Drives the OSD overlay stage and exports beam position and a frame counter.
module vga_video_gen #(
  parameter int unsigned c_bits_x    = 10,
  parameter int unsigned c_bits_y    = 10,
  parameter int unsigned c_h_visible = 640,
  parameter int unsigned c_h_fp      = 16,
  parameter int unsigned c_h_sync    = 96,
  parameter int unsigned c_h_bp      = 48,
  parameter int unsigned c_v_visible = 480,
  parameter int unsigned c_v_fp      = 10,
  parameter int unsigned c_v_sync    = 2,
  parameter int unsigned c_v_bp      = 33,
  parameter logic        c_hsync_pol = 1'b0,
  parameter logic        c_vsync_pol = 1'b0
) (
  input  logic                clk_pixel,
  input  logic                rstn,
  input  logic                clk_pixel_ena,
  input  logic [1:0]          i_pattern,
  input  logic [23:0]         i_color,
  output logic [7:0]          o_r,
  output logic [7:0]          o_g,
  output logic [7:0]          o_b,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_blank,
  output logic [c_bits_x-1:0] o_x,
  output logic [c_bits_y-1:0] o_y,
  output logic [7:0]          o_frame
);

  localparam int unsigned h_total = c_h_visible + c_h_fp + c_h_sync + c_h_bp;
  localparam int unsigned v_total = c_v_visible + c_v_fp + c_v_sync + c_v_bp;
  localparam int unsigned bar_w   = c_h_visible / 8;

  localparam logic [c_bits_x-1:0] x_last   = c_bits_x'(h_total - 1);
  localparam logic [c_bits_y-1:0] y_last   = c_bits_y'(v_total - 1);
  localparam logic [c_bits_x-1:0] x_vis    = c_bits_x'(c_h_visible);
  localparam logic [c_bits_y-1:0] y_vis    = c_bits_y'(c_v_visible);
  localparam logic [c_bits_x-1:0] hs_start = c_bits_x'(c_h_visible + c_h_fp);
  localparam logic [c_bits_x-1:0] hs_end   = c_bits_x'(c_h_visible + c_h_fp + c_h_sync);
  localparam logic [c_bits_y-1:0] vs_start = c_bits_y'(c_v_visible + c_v_fp);
  localparam logic [c_bits_y-1:0] vs_end   = c_bits_y'(c_v_visible + c_v_fp + c_v_sync);
  localparam logic [c_bits_x-1:0] bar_last = c_bits_x'(bar_w - 1);

  // Beam position, frame count, latched pattern and bar tracking state
  logic [c_bits_x-1:0] x;
  logic [c_bits_y-1:0] y;
  logic [7:0]          frame;
  logic [1:0]          pat_q;
  logic [23:0]         col_q;
  logic [2:0]          bar_idx;
  logic [c_bits_x-1:0] bar_cnt;

  // Per-pixel combinational results for the current (x,y)
  logic        frame_start_c;
  logic        blank_c;
  logic        hsync_c;
  logic        vsync_c;
  logic [1:0]  pat_c;
  logic [23:0] col_c;
  logic [23:0] rgb_c;

  // Compute sync, blank and pattern color for the pixel at (x,y)
  always_comb begin
    frame_start_c = 1'b0;
    blank_c       = 1'b1;
    hsync_c       = ~c_hsync_pol;
    vsync_c       = ~c_vsync_pol;
    pat_c         = pat_q;
    col_c         = col_q;
    rgb_c         = 24'h000000;

    frame_start_c = (x == '0) && (y == '0);
    blank_c       = (x >= x_vis) || (y >= y_vis);
    hsync_c       = ((x >= hs_start) && (x < hs_end)) ? c_hsync_pol : ~c_hsync_pol;
    vsync_c       = ((y >= vs_start) && (y < vs_end)) ? c_vsync_pol : ~c_vsync_pol;

    // The pattern sampled at frame start already governs pixel (0,0)
    if (frame_start_c) begin
      pat_c = i_pattern;
      col_c = i_color;
    end

    case (pat_c)
      2'd0:    rgb_c = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
      2'd1:    rgb_c = (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h000000;
      2'd2:    rgb_c = {x[7:0], y[7:0], frame};
      default: rgb_c = col_c;
    endcase

    if (blank_c) begin
      rgb_c = 24'h000000;
    end
  end

  // Register outputs for the current pixel and advance the raster
  always_ff @(posedge clk_pixel) begin
    if (!rstn) begin
      x       <= '0;
      y       <= '0;
      frame   <= 8'd0;
      pat_q   <= 2'd0;
      col_q   <= 24'h000000;
      bar_idx <= 3'd0;
      bar_cnt <= '0;
      o_r     <= 8'd0;
      o_g     <= 8'd0;
      o_b     <= 8'd0;
      o_blank <= 1'b1;
      o_hsync <= ~c_hsync_pol;
      o_vsync <= ~c_vsync_pol;
      o_x     <= '0;
      o_y     <= '0;
      o_frame <= 8'd0;
    end else if (clk_pixel_ena) begin
      o_r     <= rgb_c[23:16];
      o_g     <= rgb_c[15:8];
      o_b     <= rgb_c[7:0];
      o_blank <= blank_c;
      o_hsync <= hsync_c;
      o_vsync <= vsync_c;
      o_x     <= x;
      o_y     <= y;
      o_frame <= frame;

      if (frame_start_c) begin
        pat_q <= i_pattern;
        col_q <= i_color;
      end

      // Bar tracking restarts with each line so no divider is needed
      if (x == x_last) begin
        bar_idx <= 3'd0;
        bar_cnt <= '0;
      end else if (bar_cnt == bar_last) begin
        bar_idx <= bar_idx + 3'd1;
        bar_cnt <= '0;
      end else begin
        bar_cnt <= bar_cnt + c_bits_x'(1);
      end

      if (x == x_last) begin
        x <= '0;
        if (y == y_last) begin
          y     <= '0;
          frame <= frame + 8'd1;
        end else begin
          y <= y + c_bits_y'(1);
        end
      end else begin
        x <= x + c_bits_x'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_video_gen.sv
// tb_vga_video_gen: scoreboard bench for vga_video_gen.
// Horizontal timing is default; vertical timing is shortened to 24 lines per frame.
module tb_vga_video_gen;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bl;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] f;
  } vid_t;

  logic        clk_pixel;
  logic        rstn;
  logic        ena;
  logic [1:0]  i_pattern;
  logic [23:0] i_color;
  logic [7:0]  o_r, o_g, o_b;
  logic        o_hsync, o_vsync, o_blank;
  logic [9:0]  o_x, o_y;
  logic [7:0]  o_frame;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vid_t sb[$];

  vga_video_gen #(
    .c_v_visible(16),
    .c_v_fp     (2),
    .c_v_sync   (2),
    .c_v_bp     (4)
  ) dut (
    .clk_pixel    (clk_pixel),
    .rstn         (rstn),
    .clk_pixel_ena(ena),
    .i_pattern    (i_pattern),
    .i_color      (i_color),
    .o_r          (o_r),
    .o_g          (o_g),
    .o_b          (o_b),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_blank      (o_blank),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_frame      (o_frame)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  // Reference model: pushes the expected output of every clock edge
  int          mx, my;
  logic [7:0]  mf;
  logic [1:0]  mpat;
  logic [23:0] mcol;
  vid_t        mlast;
  logic [23:0] bars [8];
  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
  end

  always @(posedge clk_pixel) begin
    vid_t        e;
    logic [23:0] c;
    if (!rstn) begin
      mx = 0; my = 0; mf = 8'd0; mpat = 2'd0; mcol = 24'h0;
      e = '{8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 8'd0};
      mlast = e;
    end else if (ena) begin
      if (mx == 0 && my == 0) begin
        mpat = i_pattern;
        mcol = i_color;
      end
      case (mpat)
        2'd0:    c = bars[mx / 80];
        2'd1:    c = (((mx / 8) % 2) != ((my / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
        2'd2:    c = {8'(mx % 256), 8'(my % 256), mf};
        default: c = mcol;
      endcase
      e.bl = (mx >= 640) || (my >= 16);
      if (e.bl) c = 24'h0;
      e.r  = c[23:16];
      e.g  = c[15:8];
      e.b  = c[7:0];
      e.hs = !(mx >= 656 && mx < 752);
      e.vs = !(my >= 18 && my < 20);
      e.x  = 10'(mx);
      e.y  = 10'(my);
      e.f  = mf;
      mlast = e;
      if (mx == 799) begin
        mx = 0;
        if (my == 23) begin
          my = 0;
          mf = mf + 8'd1;
        end else begin
          my = my + 1;
        end
      end else begin
        mx = mx + 1;
      end
    end
    sb.push_back(mlast);
  end

  // Monitor: pops one expectation per edge and checks frame period
  logic per_valid = 1'b0;
  int   per_cnt   = 0;
  always @(posedge clk_pixel) begin
    vid_t a, e;
    logic was_rst, was_en;
    was_rst = !rstn;
    was_en  = ena;
    #1;
    a = '{o_r, o_g, o_b, o_hsync, o_vsync, o_blank, o_x, o_y, o_frame};
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL pixel t=%0t got rgb=%02h%02h%02h hs=%b vs=%b bl=%b x=%0d y=%0d f=%0d exp rgb=%02h%02h%02h hs=%b vs=%b bl=%b x=%0d y=%0d f=%0d",
                 $time, a.r, a.g, a.b, a.hs, a.vs, a.bl, a.x, a.y, a.f,
                 e.r, e.g, e.b, e.hs, e.vs, e.bl, e.x, e.y, e.f);
      end
    end
    if (was_rst) begin
      per_valid = 1'b0;
    end else if (was_en) begin
      if (per_valid) per_cnt++;
      if (o_x == 10'd0 && o_y == 10'd0) begin
        if (per_valid) begin
          n_cmp++;
          if (per_cnt != 19200) begin
            n_fail++;
            $display("FAIL frame_period got=%0d exp=19200", per_cnt);
          end
        end
        per_valid = 1'b1;
        per_cnt   = 0;
      end
    end
  end

  // Step enabled pixels until the output shows (tx,ty), with a cycle budget
  task automatic wait_pos(input int tx, input int ty);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 30000) begin
      @(negedge clk_pixel);
      n++;
      if (o_x == 10'(tx) && o_y == 10'(ty)) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL wait_pos target=(%0d,%0d) got=(%0d,%0d)", tx, ty, o_x, o_y);
    end
  endtask

  // Directed stimulus sequence
  initial begin
    logic gate [4];
    gate[0] = 1'b1; gate[1] = 1'b0; gate[2] = 1'b0; gate[3] = 1'b1;
    rstn      = 1'b0;
    ena       = 1'b1;
    i_pattern = 2'd0;
    i_color   = 24'h000000;
    repeat (3) @(negedge clk_pixel);
    rstn = 1'b1;

    // Frame 0 stays bars; solid 123456 takes over at frame 1
    wait_pos(100, 10);
    i_pattern = 2'd3;
    i_color   = 24'h123456;

    // Checkerboard from frame 2
    wait_pos(100, 10);
    i_pattern = 2'd1;

    // Gradient from frame 3
    wait_pos(100, 10);
    i_pattern = 2'd2;
    wait_pos(0, 3);

    // Enable gating 1,0,0,1
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_pixel);
      ena = gate[i % 4];
    end
    ena = 1'b1;

    // Mid-frame reset with enable low, then hold, then resume from (0,0)
    wait_pos(5, 12);
    rstn = 1'b0;
    ena  = 1'b0;
    @(negedge clk_pixel);
    rstn = 1'b1;
    repeat (2) @(negedge clk_pixel);
    ena = 1'b1;
    repeat (1000) @(negedge clk_pixel);
    ena = 1'b0;
    repeat (3) @(negedge clk_pixel);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_video_gen.md
# vga_video_gen

Pixel-stream source for the video pipeline. It generates VGA raster timing (hsync, vsync, blank) and a selectable test-pattern RGB stream in the same pixel format the OSD overlay stage consumes, and drives that stage directly. The OSD overlay stage then feeds DVI/TMDS encoding. The block also exports beam position and a frame counter for other stages.

## Interface
- c_bits_x, 10, width of the X counter and o_x
- c_bits_y, 10, width of the Y counter and o_y
- c_h_visible, 640, visible pixels per line
- c_h_fp, 16, horizontal front porch in pixels
- c_h_sync, 96, hsync width in pixels
- c_h_bp, 48, horizontal back porch in pixels
- c_v_visible, 480, visible lines per frame
- c_v_fp, 10, vertical front porch in lines
- c_v_sync, 2, vsync width in lines
- c_v_bp, 33, vertical back porch in lines
- c_hsync_pol, 0, active level of o_hsync
- c_vsync_pol, 0, active level of o_vsync
- clk_pixel  in  1  pixel clock
- rstn  in  1  synchronous reset, active-low
- clk_pixel_ena  in  1  pixel enable; all counters and registered outputs advance only when it is 1
- i_pattern  in  2  pattern select: 0 color bars, 1 checkerboard, 2 gradient, 3 solid
- i_color  in  24  RRGGBB color for solid pattern
- o_r, o_g, o_b  out  8 each  pixel color, 0 during blank
- o_hsync, o_vsync, o_blank  out  1 each  sync and blank, aligned with RGB
- o_x  out  c_bits_x  X of the pixel currently on o_r/o_g/o_b
- o_y  out  c_bits_y  Y of the pixel currently on o_r/o_g/o_b
- o_frame  out  8  frame counter

## Operation
- Totals: h_total = sum of the four c_h_* parameters (800 by default); v_total = sum of the four c_v_* parameters (525 by default).
- Counters: x runs 0..h_total-1. y runs 0..v_total-1.
  - x wraps to 0 and y increments when x = h_total-1.
  - y wraps to 0 when x = h_total-1 and y = v_total-1. The frame counter increments on that same cycle and wraps 255 to 0.
- Blank is active when x ≥ c_h_visible or y ≥ c_v_visible.
- hsync is active for c_h_visible+c_h_fp ≤ x < c_h_visible+c_h_fp+c_h_sync. vsync uses the same rule on y with the c_v_* parameters.
- Pattern latch: i_pattern and i_color are sampled into an active-pattern register only on the enabled cycle where x=0 and y=0, i.e. at frame start. A pattern change never tears mid-frame.
- Color bars: 8 bars, each bar_w = c_h_visible/8 pixels wide (integer; 80 by default).
  - A 3-bit bar index and a bar pixel counter reset at x=0. The index increments each time the pixel counter reaches bar_w-1. No divider is used.
  - Channel values: R = 8 copies of ~idx[1], G = 8 copies of ~idx[2], B = 8 copies of ~idx[0]. This gives white, yellow, cyan, green, magenta, red, blue, black.
- Checkerboard: white (FFFFFF) when x[3]^y[3] = 1, else black.
- Gradient: R = x[7:0], G = y[7:0], B = frame counter.
- Solid: the latched i_color.
- During blank, RGB output is forced to 0.

## Timing
- Reset (rstn=0 at a clk_pixel edge) takes effect regardless of clk_pixel_ena. Reset values:
  - x=0, y=0, frame=0, active pattern = 0 (color bars), bar counters 0.
  - o_r/o_g/o_b = 0, o_blank = 1, o_hsync = !c_hsync_pol, o_vsync = !c_vsync_pol, o_x = 0, o_y = 0, o_frame = 0.
- Reset asserted mid-frame aborts the frame. After release, the first enabled cycle outputs pixel (0,0).
- Latency: outputs are registered. On each enabled edge, every output takes the value computed from the current (x,y), and the counters advance. o_x/o_y always match the pixel shown on RGB and sync.
- When clk_pixel_ena=0, all state and outputs hold.
- Sync, blank and RGB change on the same edge. There is no skew between them.
- The pattern sampled at (0,0) applies starting with pixel (0,0) itself.

## Test plan
- Reset and first pixel: hold rstn=0 for 3 cycles with ena=1, then release. Required: during reset o_blank=1, o_hsync=1, o_vsync=1, RGB=0. The first enabled edge after release outputs o_x=0, o_y=0, RGB=FFFFFF (white bar).
- Line timing: ena=1 continuously. Required: hsync active (0) for exactly 96 enables starting at o_x=656; o_blank=1 for o_x 640..799; o_x wraps 799 to 0 and o_y increments on the same edge.
- Frame timing: run one full frame. Required: vsync active for o_y 490..491 (2 lines); o_frame increments from 0 to 1 after o_x=799, o_y=524; frame period = 420000 enables.
- Color bars: sample line 0. Required: o_x 0..79 = FFFFFF, 80..159 = FFFF00, 160..239 = 00FFFF, …, 560..639 = 000000.
- Pattern latch: set i_pattern=3 and i_color=123456 at o_x=100, o_y=10. Required: bars continue to end of frame; from the next (0,0) RGB = 123456 on all visible pixels.
- Enable gating and mid-frame reset: toggle ena 1,0,0,1. Required: outputs and counters hold while ena=0 and advance by exactly one pixel per ena=1. Then pulse rstn=0 at o_y=200. Required: next enabled output is (0,0).
